// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: arbiter states, grant codes
// and the protocol bytes used by the command FSM.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_ACCEPT = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HOLD   = 3'd4
  } arb_state_t;

  localparam logic [2:0] GRANT_CMD  = 3'd0;
  localparam logic [2:0] GRANT_NONE = 3'd7;

  localparam logic [7:0] ACK = 8'h2A;  // "*"
  localparam logic [7:0] ERR = 8'h21;  // "!"

endpackage

// File: rtl/sync_byte_fifo.sv
// Small show-ahead byte FIFO; rd_data always presents the head entry.
// A write while full is accepted only when a read frees a slot in the same cycle.
module sync_byte_fifo #(
  parameter int DEPTH = 4  // power of 2, at least 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;
  logic        do_wr;
  logic        do_rd;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_rd) rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between a FIFO-buffered command byte source and
// NUM_REQ burst-locked valid/ready requesters, one byte in flight at a time.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int CMD_FIFO_DEPTH = 4,
  parameter int HOLD_TIMEOUT   = 1023
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           cmd_tx_data,
  input  logic                 cmd_tx_wr,
  output logic                 cmd_overflow,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_wr,
  input  logic                 tx_busy,
  output logic [2:0]           grant_id,
  output logic                 lock_broken
);

  localparam int HW = $clog2(HOLD_TIMEOUT + 1);

  arb_state_t    state_reg, state_next;
  logic [2:0]    grant_reg, grant_next;
  logic [1:0]    rr_reg, rr_next;
  logic [HW-1:0] hold_cnt_reg, hold_cnt_next;
  logic          accept_cnt_reg, accept_cnt_next;
  logic          last_reg, last_next;
  logic [7:0]    tx_data_reg, tx_data_next;
  logic          tx_wr_reg, tx_wr_next;
  logic          lock_broken_reg, lock_broken_next;
  logic          overflow_reg;

  logic [7:0] fifo_head;
  logic       fifo_full, fifo_empty, fifo_pop;

  // Requester views padded to four lanes so a 2-bit index never runs off the end.
  logic [7:0] req_bytes [4];
  logic [3:0] valid4, last4;
  logic [1:0] cand_idx [4];
  logic [1:0] gidx, adv_idx, pick_idx;
  logic       pick_found;

  sync_byte_fifo #(.DEPTH(CMD_FIFO_DEPTH)) u_cmd_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (cmd_tx_wr),
    .wr_data (cmd_tx_data),
    .rd_en   (fifo_pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      if (gi < NUM_REQ) begin : g_used
        logic [2:0] rot_sum;
        assign rot_sum        = {1'b0, rr_reg} + 3'(gi);
        assign cand_idx[gi]   = (rot_sum >= 3'(NUM_REQ)) ? 2'(rot_sum - 3'(NUM_REQ)) : rot_sum[1:0];
        assign req_bytes[gi]  = req_data[8*gi +: 8];
        assign valid4[gi]     = req_valid[gi];
        assign last4[gi]      = req_last[gi];
        assign req_ready[gi]  = (state_reg == ST_LOAD) && (grant_reg == 3'(gi + 1)) && req_valid[gi];
      end else begin : g_pad
        assign cand_idx[gi]   = 2'd0;
        assign req_bytes[gi]  = 8'd0;
        assign valid4[gi]     = 1'b0;
        assign last4[gi]      = 1'b0;
      end
    end
  endgenerate

  assign gidx    = grant_reg[1:0] - 2'd1;
  assign adv_idx = (gidx == 2'(NUM_REQ - 1)) ? 2'd0 : gidx + 2'd1;

  // Scan from the farthest candidate back so the one nearest the pointer wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = 2'd0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (valid4[cand_idx[k]]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx[k];
      end
    end
  end

  always_comb begin
    state_next       = state_reg;
    grant_next       = grant_reg;
    rr_next          = rr_reg;
    hold_cnt_next    = hold_cnt_reg;
    accept_cnt_next  = accept_cnt_reg;
    last_next        = last_reg;
    tx_data_next     = tx_data_reg;
    tx_wr_next       = 1'b0;
    lock_broken_next = 1'b0;
    fifo_pop         = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        hold_cnt_next = '0;
        // A byte left over from before a reset must finish before the next load.
        if (!tx_busy) begin
          if (!fifo_empty) begin
            grant_next = GRANT_CMD;
            state_next = ST_LOAD;
          end else if (pick_found) begin
            grant_next = {1'b0, pick_idx} + 3'd1;
            state_next = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        accept_cnt_next = 1'b0;
        if (grant_reg == GRANT_CMD) begin
          fifo_pop     = 1'b1;
          tx_data_next = fifo_head;
          last_next    = 1'b1;
          tx_wr_next   = 1'b1;
          state_next   = ST_ACCEPT;
        end else if (valid4[gidx]) begin
          tx_data_next = req_bytes[gidx];
          last_next    = last4[gidx];
          tx_wr_next   = 1'b1;
          state_next   = ST_ACCEPT;
        end else begin
          state_next   = ST_HOLD;
        end
      end
      ST_ACCEPT: begin
        if (tx_busy || accept_cnt_reg) state_next = ST_DRAIN;
        else                           accept_cnt_next = 1'b1;
      end
      ST_DRAIN: begin
        if (!tx_busy) begin
          if (grant_reg == GRANT_CMD || last_reg) begin
            if (grant_reg != GRANT_CMD) rr_next = adv_idx;
            grant_next = GRANT_NONE;
            state_next = ST_IDLE;
          end else begin
            hold_cnt_next = '0;
            state_next    = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (valid4[gidx]) begin
          state_next = ST_LOAD;
        end else if (hold_cnt_reg == HW'(HOLD_TIMEOUT - 1)) begin
          lock_broken_next = 1'b1;
          rr_next          = adv_idx;
          grant_next       = GRANT_NONE;
          state_next       = ST_IDLE;
        end else begin
          hold_cnt_next = hold_cnt_reg + 1'b1;
        end
      end
      default: begin
        grant_next = GRANT_NONE;
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      grant_reg       <= GRANT_NONE;
      rr_reg          <= '0;
      hold_cnt_reg    <= '0;
      accept_cnt_reg  <= 1'b0;
      last_reg        <= 1'b0;
      tx_data_reg     <= '0;
      tx_wr_reg       <= 1'b0;
      lock_broken_reg <= 1'b0;
      overflow_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      grant_reg       <= grant_next;
      rr_reg          <= rr_next;
      hold_cnt_reg    <= hold_cnt_next;
      accept_cnt_reg  <= accept_cnt_next;
      last_reg        <= last_next;
      tx_data_reg     <= tx_data_next;
      tx_wr_reg       <= tx_wr_next;
      lock_broken_reg <= lock_broken_next;
      overflow_reg    <= overflow_reg | (cmd_tx_wr & fifo_full & ~fifo_pop);
    end
  end

  assign tx_data      = tx_data_reg;
  assign tx_wr        = tx_wr_reg;
  assign grant_id     = grant_reg;
  assign lock_broken  = lock_broken_reg;
  assign cmd_overflow = overflow_reg;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter between the command FSM (echo / ack / status bytes) and NUM_REQ streaming requesters, such as the FIFO sample readout and status dump.
- Command-FSM bytes are one-cycle write pulses with no backpressure, so they are captured in a small FIFO.
- Streaming requesters use a valid/ready handshake with burst locking: a multi-byte record is never interleaved with other traffic.
- Sits between the command FSM / data readout and the UART TX core.

Parameters:
- NUM_REQ, 2, number of handshaked streaming requesters (1..4).
- CMD_FIFO_DEPTH, 4, command-byte capture FIFO depth (power of 2).
- HOLD_TIMEOUT, 1023, cycles a locked requester may leave req_valid low mid-burst before its lock is broken.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- cmd_tx_data  in  8  command-FSM byte
- cmd_tx_wr  in  1  one-cycle write strobe for cmd_tx_data
- cmd_overflow  out  1  sticky; set when cmd_tx_wr arrives with the FIFO full; cleared only by rst
- req_data  in  8*NUM_REQ  requester bytes; requester i occupies bits [8i+7:8i]
- req_valid  in  NUM_REQ  byte valid
- req_last  in  NUM_REQ  byte is the last of its burst
- req_ready  out  NUM_REQ  byte accepted this cycle (transfer = valid & ready)
- tx_data  out  8  byte to UART core
- tx_wr  out  1  one-cycle load strobe to UART core
- tx_busy  in  1  UART core busy; rises the cycle after tx_wr, falls when the stop bit is done
- grant_id  out  3  0 = command FIFO, i+1 = requester i, 7 = none
- lock_broken  out  1  one-cycle pulse when HOLD_TIMEOUT fires

Behaviour:
- Reset values: tx_data=0, tx_wr=0, req_ready=0, grant_id=7, cmd_overflow=0, lock_broken=0. FIFO empty, state IDLE, round-robin pointer=0.
- Reset mid-operation: FIFO contents are discarded; a byte already handed to the UART completes on its own.
- Command FIFO:
  - Writes whenever cmd_tx_wr=1 and not full.
  - A write while full drops the byte and sets cmd_overflow.
  - Write and read in the same cycle while full is legal: the read frees the slot and the write is accepted.
- States:
  - IDLE:
    - FIFO non-empty → grant 0, go to LOAD.
    - Otherwise, any req_valid → grant the first valid requester at or after the RR pointer, wrapping; go to LOAD.
    - Command FIFO always wins at IDLE.
  - LOAD:
    - Command grant: pop the FIFO; tx_data ← head.
    - Requester grant: req_ready[i]=1 for exactly this cycle (combinational from state and valid); tx_data ← req_data[i].
    - tx_wr=1 the following cycle (registered); go to ACCEPT.
  - ACCEPT:
    - Wait for tx_busy=1, then go to DRAIN.
    - If tx_busy is not seen within 2 cycles, go to DRAIN anyway; this is a UART-core fault tolerance, not an error output.
  - DRAIN: wait for tx_busy=0. Then:
    - Command grant → IDLE.
    - Requester grant, and the last transferred byte had req_last=1 → advance the RR pointer to i+1 (wrap), then IDLE.
    - Requester grant, no last yet → HOLD (lock kept).
  - HOLD:
    - req_valid[i]=1 → LOAD with the same grant.
    - Otherwise increment the hold counter.
    - Counter reaching HOLD_TIMEOUT → pulse lock_broken, advance the RR pointer, go to IDLE.
    - Command bytes wait during HOLD; bursts are never interleaved.
- Throughput: at most one byte in flight; the next byte never loads before tx_busy falls.
- grant_id is valid from LOAD through DRAIN/HOLD, and is 7 in IDLE.
- NUM_REQ=1: the RR pointer stays at 0.

Decomposition:
- Shared package (uart_pkg):
  - Arbiter state encoding.
  - GRANT_NONE=3'd7, GRANT_CMD=3'd0.
  - ASCII constants ACK="*", ERR="!".
- Sub-module: sync_byte_fifo (parameterised depth; full/empty flags; simultaneous read/write) used for command capture.

Test Plan:
- Single command byte: cmd_tx_wr pulse with 0x2A, UART model busy for 10 cycles → exactly one tx_wr, tx_data=0x2A, grant_id 0 then 7.
- FIFO overflow: 5 back-to-back cmd_tx_wr pulses (0x41..0x45) while tx_busy is held high → bytes 0x41..0x44 sent in order, 0x45 dropped, cmd_overflow=1 and remaining set.
- Burst lock: requester 0 sends a 3-byte burst (last on byte 3) while a command byte arrives mid-burst → UART order is burst bytes 1, 2, 3, then the command byte.
- Round-robin fairness: both requesters stream continuous 1-byte bursts → grants alternate 1, 2, 1, 2; command bytes are inserted at every burst boundary when pending.
- Hold timeout: requester 0 sends a byte with last=0 then drops valid → lock_broken pulses at HOLD_TIMEOUT, and requester 1 is then granted.
- Async reset asserted during DRAIN → all outputs take their reset values immediately, and the next cmd_tx_wr is transmitted normally.
